// File: rtl/apb_gpio_master_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_master_arb_if
// Desc     : Requester handshake and APB bus bundle for apb_gpio_master_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_gpio_master_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    logic                PSEL;
    logic                PENABLE;
    logic [ADDR_W-1:0]   PADDR;
    logic                PWRITE;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_gpio_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_master_arb
// Desc     : Two-requester round-robin APB master in front of apb_gpio.
//            Optional ACCESS-phase timeout abort: define APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_master_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  wire logic              PCLK,
    input  wire logic              PRESETn,
    apb_gpio_master_arb_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              state_q;
    logic                gnt_q;
    logic                last_gnt_q;
    logic                psel_q;
    logic                penable_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [1:0]          req_ready_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic                gnt_d;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_write;

`ifdef APB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]    cnt_q;
    logic                rsp_err_q;

    assign bus.rsp_err = rsp_err_q;
`else
    logic                w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign bus.rsp_err      = 1'b0;
`endif

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        gnt_d = 1'b0;
        case (bus.req_valid)
            2'b10:   gnt_d = 1'b1;
            2'b11:   gnt_d = ~last_gnt_q;
            default: gnt_d = 1'b0;
        endcase
    end

    assign w_sel_addr  = gnt_d ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
    assign w_sel_wdata = gnt_d ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
    assign w_sel_write = gnt_d ? bus.req_write[1]                 : bus.req_write[0];

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        state_q     <= S_SETUP;
                        gnt_q       <= gnt_d;
                        last_gnt_q  <= gnt_d;
                        paddr_q     <= w_sel_addr;
                        pwrite_q    <= w_sel_write;
                        pwdata_q    <= w_sel_wdata;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        req_ready_q <= {gnt_d, ~gnt_d};
`ifdef APB_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end

                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                end

                S_ACCESS: begin
                    if (bus.PREADY) begin
                        state_q     <= S_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= {gnt_q, ~gnt_q};
                        if (!pwrite_q) begin
                            rsp_rdata_q <= bus.PRDATA;
                        end
`ifdef APB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Limit reached with the slave still stalling: abort.
                        state_q     <= S_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= {gnt_q, ~gnt_q};
                        rsp_rdata_q <= {DATA_W{1'b1}};
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + CNT_W'(1);
`endif
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_master_arb
// Desc     : Randomised scoreboard bench for apb_gpio_master_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_master_arb;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic       who;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic       who;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_gpio_master_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_gpio_master_arb #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    xfer_t      drv_q0[$];
    xfer_t      drv_q1[$];
    xfer_t      exp_setup[$];
    rsp_t       exp_rsp[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_mem[256];
    logic [7:0] slave_mem[256];
    logic       model_last;
    logic [7:0] model_hold;
    int         force_waits = -1;
    int         slave_waits = 0;
    bit         drv_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: one completed transfer in arbitration order.
    task automatic model_xfer(input xfer_t t);
        rsp_t r;
        exp_setup.push_back(t);
        if (t.wr) model_mem[t.addr] = t.wdata;
        else      model_hold = model_mem[t.addr];
        r.who   = t.who;
        r.rdata = model_hold;
        r.err   = 1'b0;
        exp_rsp.push_back(r);
        model_last = t.who;
    endtask

    task automatic rand_xfer(input logic who, output xfer_t t);
        t.who   = who;
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = 8'($urandom_range(0, 7));
        t.wdata = 8'($urandom);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_setup.size() != 0 || exp_rsp.size() != 0 ||
                drv_q0.size() != 0 || drv_q1.size() != 0) && n < 400) begin
            @(negedge PCLK);
            n++;
        end
        chk({name, "_outstanding"}, 32'(exp_rsp.size() + exp_setup.size()), 0);
        exp_setup.delete();
        exp_rsp.delete();
        drv_q0.delete();
        drv_q1.delete();
    endtask

    task automatic measure_access(output int cyc);
        int n = 0;
        cyc = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!(bus.PSEL && bus.PENABLE) && n < 50);
        while (bus.PSEL && bus.PENABLE && n < 100) begin
            cyc++;
            @(negedge PCLK);
            n++;
        end
    endtask

    task automatic run_round(input bit force_both);
        xfer_t l0[$];
        xfer_t l1[$];
        xfer_t t;
        int    n0;
        int    n1;
        logic  pick;
        n0 = force_both ? $urandom_range(1, 3) : $urandom_range(0, 3);
        n1 = force_both ? $urandom_range(1, 3) : $urandom_range(0, 3);
        if (n0 + n1 == 0) n0 = 1;
        @(posedge PCLK);
        #1;
        for (int k = 0; k < n0; k++) begin rand_xfer(1'b0, t); l0.push_back(t); drv_q0.push_back(t); end
        for (int k = 0; k < n1; k++) begin rand_xfer(1'b1, t); l1.push_back(t); drv_q1.push_back(t); end
        while (l0.size() != 0 || l1.size() != 0) begin
            if (l0.size() != 0 && l1.size() != 0) pick = ~model_last;
            else                                  pick = (l1.size() != 0);
            if (pick) t = l1.pop_front();
            else      t = l0.pop_front();
            model_xfer(t);
        end
        drain("round");
        repeat ($urandom_range(0, 3)) @(negedge PCLK);
    endtask

    // Requester drivers: hold the head request until its req_ready pulse.
    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        forever begin
            @(negedge PCLK);
            if (drv_en) begin
                if (bus.req_ready[0] && bus.req_valid[0] && drv_q0.size() != 0) void'(drv_q0.pop_front());
                if (bus.req_ready[1] && bus.req_valid[1] && drv_q1.size() != 0) void'(drv_q1.pop_front());
                bus.req_valid[0] = (drv_q0.size() != 0);
                bus.req_valid[1] = (drv_q1.size() != 0);
                if (drv_q0.size() != 0) begin
                    bus.req_write[0]    = drv_q0[0].wr;
                    bus.req_addr[7:0]   = drv_q0[0].addr;
                    bus.req_wdata[7:0]  = drv_q0[0].wdata;
                end
                if (drv_q1.size() != 0) begin
                    bus.req_write[1]    = drv_q1[0].wr;
                    bus.req_addr[15:8]  = drv_q1[0].addr;
                    bus.req_wdata[15:8] = drv_q1[0].wdata;
                end
            end
        end
    end

    // APB slave: memory with random or forced wait states.
    initial begin
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && !bus.PENABLE) begin
                slave_waits = (force_waits >= 0) ? force_waits : $urandom_range(0, 3);
                bus.PREADY  = 1'b0;
                bus.PRDATA  = 8'($urandom);
            end else if (bus.PSEL && bus.PENABLE) begin
                if (slave_waits > 0) begin
                    slave_waits--;
                    bus.PREADY = 1'b0;
                    bus.PRDATA = 8'($urandom);
                end else begin
                    bus.PREADY = 1'b1;
                    if (bus.PWRITE) slave_mem[bus.PADDR] = bus.PWDATA;
                    else            bus.PRDATA = slave_mem[bus.PADDR];
                end
            end else begin
                bus.PREADY = 1'b0;
                bus.PRDATA = 8'($urandom);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        xfer_t cur;
        rsp_t  r;
        cur = '0;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (bus.PSEL && !bus.PENABLE) begin
                    if (exp_setup.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_setup actual=PADDR %0h required=no pending transfer", bus.PADDR);
                    end else begin
                        cur = exp_setup.pop_front();
                        chk("setup_paddr", 32'(bus.PADDR), 32'(cur.addr));
                        chk("setup_pwrite", 32'(bus.PWRITE), 32'(cur.wr));
                        chk("setup_pwdata", 32'(bus.PWDATA), 32'(cur.wdata));
                        chk("setup_req_ready", 32'(bus.req_ready), cur.who ? 32'd2 : 32'd1);
                    end
                end else if (bus.PSEL && bus.PENABLE) begin
                    chk("access_stable", 32'({bus.PADDR, bus.PWRITE, bus.PWDATA}),
                        32'({cur.addr, cur.wr, cur.wdata}));
                    chk("access_req_ready", 32'(bus.req_ready), 0);
                end
                if (bus.rsp_valid != 2'b00) begin
                    if (exp_rsp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp actual=rsp_valid %0b required=no pending response", bus.rsp_valid);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_valid", 32'(bus.rsp_valid), r.who ? 32'd2 : 32'd1);
                        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
                        chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
                        chk("rsp_idle_psel", 32'({bus.PSEL, bus.PENABLE, bus.req_ready}), 0);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        xfer_t t;
        rsp_t  r;
        int    cyc;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'h00;
            slave_mem[i] = 8'h00;
        end
        model_last = 1'b1;
        model_hold = 8'h00;

        // Reset with both requesters asserted.
        PRESETn       = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b11;
        bus.req_addr  = 16'h0201;
        bus.req_wdata = 16'h3309;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", 32'(bus.PSEL), 0);
        chk("rst_penable", 32'(bus.PENABLE), 0);
        chk("rst_paddr", 32'(bus.PADDR), 0);
        chk("rst_pwrite", 32'(bus.PWRITE), 0);
        chk("rst_pwdata", 32'(bus.PWDATA), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 0);
        bus.req_valid = 2'b00;
        PRESETn       = 1'b1;
        drv_en        = 1'b1;

        run_round(1'b1);
        for (int k = 0; k < 12; k++) run_round(1'b0);

        // Reset while stalled in ACCESS.
        force_waits = 1000;
        @(posedge PCLK);
        #1;
        rand_xfer(1'($urandom_range(0, 1)), t);
        exp_setup.push_back(t);
        if (t.who) drv_q1.push_back(t);
        else       drv_q0.push_back(t);
        cyc = 0;
        do begin
            @(negedge PCLK);
            cyc++;
        end while (!(bus.PSEL && bus.PENABLE) && cyc < 50);
        chk("midrst_in_access", 32'(bus.PSEL && bus.PENABLE), 1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        chk("midrst_psel_penable", 32'({bus.PSEL, bus.PENABLE}), 0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("midrst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        PRESETn     = 1'b1;
        force_waits = -1;
        model_last  = 1'b1;
        model_hold  = 8'h00;
        exp_setup.delete();
        drv_q0.delete();
        drv_q1.delete();
        repeat (3) begin
            @(negedge PCLK);
            chk("postrst_idle", 32'({bus.PSEL, bus.rsp_valid}), 0);
        end

        run_round(1'b1);
        for (int k = 0; k < 8; k++) run_round(1'b0);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abort after TIMEOUT ACCESS cycles.
        force_waits = 1000;
        @(posedge PCLK);
        #1;
        rand_xfer(1'b1, t);
        t.wr = 1'b0;
        exp_setup.push_back(t);
        r.who   = 1'b1;
        r.rdata = 8'hFF;
        r.err   = 1'b1;
        exp_rsp.push_back(r);
        model_hold = 8'hFF;
        model_last = 1'b1;
        drv_q1.push_back(t);
        measure_access(cyc);
        chk("timeout_access_cycles", 32'(cyc), TIMEOUT);
        drain("timeout");

        // Ready on the last allowed cycle wins over the abort.
        force_waits = TIMEOUT - 1;
        @(posedge PCLK);
        #1;
        rand_xfer(1'b0, t);
        t.wr = 1'b0;
        model_xfer(t);
        drv_q0.push_back(t);
        measure_access(cyc);
        chk("ready_at_limit_cycles", 32'(cyc), TIMEOUT);
        drain("ready_at_limit");
        force_waits = -1;
`endif

        for (int k = 0; k < 4; k++) run_round(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
